// File: rtl/line_mem_arbiter_pkg.sv
// rtl/line_mem_arbiter_pkg.sv - shared widths, FSM states and requester ids
package line_mem_pkg;

  localparam int LM_ADDR_W = 12;
  localparam int LM_LINE_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FETCH,
    ST_DONE
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/line_mem_arbiter_if.sv
// rtl/line_mem_arbiter_if.sv - line-wide backing memory port
interface line_mem_arbiter_if
  import line_mem_pkg::*;
#(
  parameter int ADDR_W = LM_ADDR_W,
  parameter int LINE_W = LM_LINE_W
) ();

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/line_mem_arbiter_rr_arb2.sv
// rtl/line_mem_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
  import line_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = REQ_I;
    // On contention the requester that did not win last time goes next.
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - shares one line memory port between I- and D-cache misses
module line_mem_arbiter
  import line_mem_pkg::*;
#(
  parameter int ADDR_W = LM_ADDR_W,
  parameter int LINE_W = LM_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_wb,
  input  logic [ADDR_W-1:0] r0_wb_addr,
  input  logic [LINE_W-1:0] r0_wb_data,
  input  logic [ADDR_W-1:0] r0_fetch_addr,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_wb,
  input  logic [ADDR_W-1:0] r1_wb_addr,
  input  logic [LINE_W-1:0] r1_wb_data,
  input  logic [ADDR_W-1:0] r1_fetch_addr,
  output logic              r1_done,
  output logic [LINE_W-1:0] line_data,
  output logic              busy,
  line_mem_arbiter_if.master mem
);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] line_data_q, line_data_d;
  logic              r0_done_q, r0_done_d;
  logic              r1_done_q, r1_done_d;
  logic              busy_q, busy_d;

  logic              arb_grant;
  logic              arb_any;
  logic              sel_wb;
  logic [ADDR_W-1:0] sel_wb_addr;
  logic [LINE_W-1:0] sel_wb_data;
  logic [ADDR_W-1:0] sel_fetch_addr;

  rr_arb2 u_rr_arb2 (
    .req        ({r1_req, r0_req}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  always_comb begin
    sel_wb         = (arb_grant == REQ_D) ? r1_wb         : r0_wb;
    sel_wb_addr    = (arb_grant == REQ_D) ? r1_wb_addr    : r0_wb_addr;
    sel_wb_data    = (arb_grant == REQ_D) ? r1_wb_data    : r0_wb_data;
    sel_fetch_addr = (arb_grant == REQ_D) ? r1_fetch_addr : r0_fetch_addr;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    fetch_addr_d = fetch_addr_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    line_data_d  = line_data_q;
    r0_done_d    = 1'b0;
    r1_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The victim address/data live in mem_addr/mem_wdata from here on,
        // so later changes on the request inputs cannot disturb the access.
        if (arb_any) begin
          grant_d      = arb_grant;
          fetch_addr_d = sel_fetch_addr;
          mem_en_d     = 1'b1;
          mem_we_d     = sel_wb;
          mem_addr_d   = sel_wb ? sel_wb_addr : sel_fetch_addr;
          mem_wdata_d  = sel_wb ? sel_wb_data : mem_wdata_q;
          state_d      = sel_wb ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        if (mem.mem_ready) begin
          mem_we_d   = 1'b0;
          mem_addr_d = fetch_addr_q;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem.mem_ready) begin
          line_data_d = mem.mem_rdata;
          mem_en_d    = 1'b0;
          r0_done_d   = (grant_q == REQ_I);
          r1_done_d   = (grant_q == REQ_D);
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_I;
      last_grant_q <= REQ_D;
      fetch_addr_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      line_data_q  <= '0;
      r0_done_q    <= 1'b0;
      r1_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      fetch_addr_q <= fetch_addr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      line_data_q  <= line_data_d;
      r0_done_q    <= r0_done_d;
      r1_done_q    <= r1_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mem.mem_en    = mem_en_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign line_data     = line_data_q;
  assign r0_done       = r0_done_q;
  assign r1_done       = r1_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - directed vector bench for line_mem_arbiter
module tb_line_mem_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_wb, r1_req, r1_wb;
  logic [11:0]   r0_wb_addr, r0_fetch_addr, r1_wb_addr, r1_fetch_addr;
  logic [255:0]  r0_wb_data, r1_wb_data;
  logic          r0_done, r1_done, busy;
  logic [255:0]  line_data;

  int n_vec = 0;
  int n_err = 0;

  line_mem_arbiter_if mem_bus ();

  line_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .r0_req        (r0_req),
    .r0_wb         (r0_wb),
    .r0_wb_addr    (r0_wb_addr),
    .r0_wb_data    (r0_wb_data),
    .r0_fetch_addr (r0_fetch_addr),
    .r0_done       (r0_done),
    .r1_req        (r1_req),
    .r1_wb         (r1_wb),
    .r1_wb_addr    (r1_wb_addr),
    .r1_wb_data    (r1_wb_data),
    .r1_fetch_addr (r1_fetch_addr),
    .r1_done       (r1_done),
    .line_data     (line_data),
    .busy          (busy),
    .mem           (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0_req, r1_req, r0_wb, r1_wb;
    logic [11:0] r0_wba, r0_fa, r1_wba, r1_fa;
    int          waits;
    logic [15:0] rword;
    logic        exp_gnt, exp_wb;
    logic [11:0] exp_wba, exp_fa;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic q0, input logic q1, input logic w0, input logic w1,
                              input logic [11:0] a0w, input logic [11:0] a0f,
                              input logic [11:0] a1w, input logic [11:0] a1f,
                              input int wt, input logic [15:0] rw, input logic g,
                              input logic ew, input logic [11:0] ewa, input logic [11:0] efa);
    vec_t v;
    v.r0_req = q0; v.r1_req = q1; v.r0_wb = w0; v.r1_wb = w1;
    v.r0_wba = a0w; v.r0_fa = a0f; v.r1_wba = a1w; v.r1_fa = a1f;
    v.waits = wt; v.rword = rw; v.exp_gnt = g; v.exp_wb = ew;
    v.exp_wba = ewa; v.exp_fa = efa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic do_access(input int idx, input vec_t v);
    logic [255:0] exp_wdata;
    exp_wdata = v.exp_gnt ? {16{16'hD1D1}} : {16{16'hD0D0}};
    @(negedge clk);
    r0_req = v.r0_req; r1_req = v.r1_req; r0_wb = v.r0_wb; r1_wb = v.r1_wb;
    r0_wb_addr = v.r0_wba; r0_fetch_addr = v.r0_fa;
    r1_wb_addr = v.r1_wba; r1_fetch_addr = v.r1_fa;
    r0_wb_data = {16{16'hD0D0}}; r1_wb_data = {16{16'hD1D1}};
    @(negedge clk);
    chk($sformatf("v%0d_grant_en", idx), 256'({busy, mem_bus.mem_en}), 256'(2'b11));
    chk($sformatf("v%0d_first_we", idx), 256'(mem_bus.mem_we), 256'(v.exp_wb));
    chk($sformatf("v%0d_first_addr", idx), 256'(mem_bus.mem_addr),
        256'(v.exp_wb ? v.exp_wba : v.exp_fa));
    // Scramble inputs after the grant; the latched access must not notice.
    r0_req = 1'b0; r1_req = 1'b0; r0_wb = ~r0_wb; r1_wb = ~r1_wb;
    r0_wb_addr = ~r0_wb_addr; r0_fetch_addr = ~r0_fetch_addr;
    r1_wb_addr = ~r1_wb_addr; r1_fetch_addr = ~r1_fetch_addr;
    r0_wb_data = ~r0_wb_data; r1_wb_data = ~r1_wb_data;
    if (v.exp_wb) begin
      for (int i = 0; i < v.waits; i++) @(negedge clk);
      chk($sformatf("v%0d_wb_hold", idx),
          256'({mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_addr}), 256'({2'b11, v.exp_wba}));
      chk($sformatf("v%0d_wdata", idx), mem_bus.mem_wdata, exp_wdata);
      mem_bus.mem_ready = 1'b1;
      @(negedge clk);
      mem_bus.mem_ready = 1'b0;
      chk($sformatf("v%0d_fetch_after_wb", idx),
          256'({mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_addr}), 256'({2'b10, v.exp_fa}));
    end
    for (int i = 0; i < v.waits; i++) @(negedge clk);
    chk($sformatf("v%0d_fetch_wait", idx),
        256'({r0_done, r1_done, mem_bus.mem_en, mem_bus.mem_addr}), 256'({3'b001, v.exp_fa}));
    mem_bus.mem_rdata = {16{v.rword}};
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    chk($sformatf("v%0d_done", idx), 256'({r0_done, r1_done, mem_bus.mem_en, busy}),
        256'({~v.exp_gnt, v.exp_gnt, 1'b0, 1'b1}));
    chk($sformatf("v%0d_line", idx), line_data, {16{v.rword}});
    @(negedge clk);
    chk($sformatf("v%0d_after", idx), 256'({r0_done, r1_done, busy}), 256'(3'b000));
  endtask

  initial begin
    logic [3:0] alt_exp;
    int got;

    vecs[0] = mk(1, 0, 0, 0, 12'h000, 12'h123, 12'h000, 12'h000, 0, 16'hA5A5, 0, 0, 12'h000, 12'h123);
    vecs[1] = mk(0, 1, 0, 1, 12'h000, 12'h000, 12'h040, 12'h080, 3, 16'h3C3C, 1, 1, 12'h040, 12'h080);
    vecs[2] = mk(1, 1, 1, 0, 12'h111, 12'h222, 12'h000, 12'h333, 1, 16'h1234, 0, 1, 12'h111, 12'h222);
    vecs[3] = mk(1, 1, 1, 0, 12'h111, 12'h222, 12'h000, 12'h333, 2, 16'h5678, 1, 0, 12'h000, 12'h333);
    vecs[4] = mk(1, 1, 0, 1, 12'h0AB, 12'h0CD, 12'h0EF, 12'hFFE, 0, 16'h9ABC, 0, 0, 12'h000, 12'h0CD);
    vecs[5] = mk(1, 0, 1, 1, 12'h7FF, 12'h800, 12'h001, 12'h002, 0, 16'hDEF0, 0, 1, 12'h7FF, 12'h800);
    vecs[6] = mk(1, 1, 0, 1, 12'h010, 12'h020, 12'h030, 12'h040, 2, 16'h0F0F, 1, 1, 12'h030, 12'h040);
    vecs[7] = mk(1, 0, 0, 0, 12'h000, 12'hFFF, 12'h000, 12'h000, 1, 16'hFFFF, 0, 0, 12'h000, 12'hFFF);

    rst = 1'b1;
    r0_req = 0; r1_req = 0; r0_wb = 0; r1_wb = 0;
    r0_wb_addr = '0; r0_fetch_addr = '0; r1_wb_addr = '0; r1_fetch_addr = '0;
    r0_wb_data = '0; r1_wb_data = '0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", 256'({mem_bus.mem_en, mem_bus.mem_we, r0_done, r1_done, busy}), 256'(5'b0));
    chk("rst_addr", 256'(mem_bus.mem_addr), 256'(12'h000));
    chk("rst_wdata", mem_bus.mem_wdata, '0);
    chk("rst_line", line_data, '0);

    mem_bus.mem_rdata = {256{1'b1}};
    mem_bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready_ctrl", 256'({mem_bus.mem_en, r0_done, r1_done, busy}), 256'(4'b0));
    chk("idle_ready_line", line_data, '0);
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;

    for (int i = 0; i < 8; i++) do_access(i, vecs[i]);

    // Abort an in-flight fetch with reset; last_grant is 0 here and must return to 1.
    @(negedge clk);
    r1_req = 1'b1; r1_wb = 1'b0; r1_fetch_addr = 12'h3AB;
    @(negedge clk);
    r1_req = 1'b0;
    chk("abort_fetch_addr", 256'({mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_addr}), 256'({2'b10, 12'h3AB}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", 256'({mem_bus.mem_en, mem_bus.mem_we, r0_done, r1_done, busy}), 256'(5'b0));
    chk("abort_addr", 256'(mem_bus.mem_addr), 256'(12'h000));
    chk("abort_data", {line_data[127:0], mem_bus.mem_wdata[127:0]}, '0);
    rst = 1'b0;

    // Both held from reset: r0, r1, r0, r1.
    r0_req = 1'b1; r1_req = 1'b1; r0_wb = 1'b0; r1_wb = 1'b0;
    r0_fetch_addr = 12'h100; r1_fetch_addr = 12'h200;
    mem_bus.mem_rdata = {16{16'h7E7E}};
    mem_bus.mem_ready = 1'b1;
    alt_exp = 4'b1010;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (r0_done || r1_done) begin
        chk($sformatf("alt_order%0d", got), 256'({r0_done, r1_done}),
            256'({~alt_exp[got], alt_exp[got]}));
        got++;
      end
    end
    if (got < 4) chk("alt_timeout", 256'(got), 256'(4));
    r0_req = 1'b0; r1_req = 1'b0;
    mem_bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", 256'({busy, mem_bus.mem_en}), 256'(2'b00));
    chk("final_line", line_data, {16{16'h7E7E}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
